// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the frequency divider.
// Default half-period and counter width sizing.
package freq_div_pkg;

    localparam int FREQ_DIV_DEFAULT_N = 8;

    // Counter must be able to hold the value n itself.
    function automatic int freq_div_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/freq_div_counter.sv
// Reloading 1..N counter with terminal-count flag (tc high while cnt == N).
// Latency: tc is combinational from the registered count; no backpressure.
// Backpressure: none, free-running every clk edge unless rst is high.
module freq_div_counter
    import freq_div_pkg::*;
#(
    parameter int N = FREQ_DIV_DEFAULT_N
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam int CNT_W = freq_div_cnt_w(N);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(N);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Declaration initialiser gives the power-up state without needing a reset pulse.
    logic [CNT_W-1:0] cnt = '0;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + ONE;
        if (cnt == TERM) begin
            cnt_nxt = ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign tc = (cnt == TERM);

endmodule

// File: rtl/frequency_divider.sv
// Divides clk by 2*N into a registered 50% square wave on out_clk.
// Latency: out_clk toggles on edge N+1 after reset/power-up, then every N edges.
// Backpressure: none; optional tick (FREQ_DIV_TICK_EN) pulses the cycle after each toggle.
module frequency_divider
    import freq_div_pkg::*;
#(
    parameter int N = FREQ_DIV_DEFAULT_N
) (
    input  logic clk,
    input  logic rst,
`ifdef FREQ_DIV_TICK_EN
    output logic tick,
`endif
    output logic out_clk
);

    generate
        if (N < 1) begin : g_bad_n
            $error("frequency_divider: N must be >= 1");
        end
    endgenerate

    logic tc;
    logic out_q = 1'b0;

    freq_div_counter #(
        .N (N)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else if (tc) begin
            out_q <= ~out_q;
        end
    end

    assign out_clk = out_q;

`ifdef FREQ_DIV_TICK_EN
    // Registered from the same tc that toggles out_q, so it lines up with the new level.
    logic tick_q = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tc;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_frequency_divider.sv
// Directed bench: N=8 and N=1 dividers sharing clk/rst, checked against an edge-count model.
module tb_frequency_divider;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic out8;
    logic out1;
`ifdef FREQ_DIV_TICK_EN
    logic tick8;
    logic tick1;
`endif

    int total = 0;
    int bad   = 0;
    int e     = 0;

    always #5 clk = ~clk;

    frequency_divider #(.N(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
`ifdef FREQ_DIV_TICK_EN
        .tick    (tick8),
`endif
        .out_clk (out8)
    );

    frequency_divider #(.N(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
`ifdef FREQ_DIV_TICK_EN
        .tick    (tick1),
`endif
        .out_clk (out1)
    );

    // Expected out_clk after edge e (counted from power-up / reset release; 0 = reset or power-up).
    function automatic logic exp_out(input int edge_n, input int n);
        if (edge_n <= n) return 1'b0;
        return 1'(((edge_n - 1) / n) % 2);
    endfunction

    function automatic logic exp_tick(input int edge_n, input int n);
        return (edge_n >= n + 1) && (((edge_n - 1) % n) == 0);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("out_n8", out8, exp_out(e, 8));
        chk("out_n1", out1, exp_out(e, 1));
`ifdef FREQ_DIV_TICK_EN
        chk("tick_n8", tick8, exp_tick(e, 8));
        chk("tick_n1", tick1, exp_tick(e, 1));
`endif
    endtask

    // Drive rst for one edge, advance the model, then sample on the falling edge.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        if (r) e = 0;
        else   e = e + 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Power-up state, no reset ever applied.
        #1;
        check_all();

        // Free run from power-up: edges 1..28 (out8 = 1 after edge 28).
        for (int i = 0; i < 28; i++) step(1'b0);
        chk("out_n8_edge28_high", out8, 1'b1);

        // Single-edge reset while out_clk is high, then 16 edges of restart.
        step(1'b1);
        chk("out_n8_after_reset", out8, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0);

        // Held reset for 5 edges, then release and run through two toggles.
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 8; i++) step(1'b0);
        chk("out_n8_still_low_edge8", out8, 1'b0);
        step(1'b0);
        chk("out_n8_first_toggle_edge9", out8, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
